// File: rtl/aes_dec_pkg.sv
// Shared constants, FSM state type and GF(2^8) / S-box helpers for the AES-128 decryptor.
package aes_dec_pkg;

  localparam int unsigned Nk         = 4;
  localparam int unsigned Nr         = 10;
  localparam int unsigned ROUND_KEYS = 11;
  localparam int unsigned KeyBits    = 32 * Nk;
  localparam int unsigned RcWidth    = $clog2(ROUND_KEYS);

  localparam logic [RcWidth-1:0] RcLast  = RcWidth'(Nr);
  localparam logic [RcWidth-1:0] RcRound = RcWidth'(Nr - 1);
  localparam logic [RcWidth-1:0] RcOne   = RcWidth'(1);

  typedef enum logic [2:0] {
    StIdle,
    StKeyExp,
    StAddKey,
    StRound,
    StFinal,
    StDone
  } aes_state_e;

  // Rcon[1..10]; index 0 and out-of-range entries are never used.
  function automatic logic [7:0] rcon(input logic [RcWidth-1:0] r);
    logic [7:0] v;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ m;
      m = xtime(m);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_decrypt_top_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] ark;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Byte 4c+r sits at row r, column c; row r is rotated right by r on the way back.
  always_comb begin
    ark       = '0;
    state_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127 - 8*(4*c + r) -: 8] =
            inv_sbox(state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]) ^
            round_key[127 - 8*(4*c + r) -: 8];
      end
    end
    if (last_round) begin
      state_out = ark;
    end else begin
      for (int c = 0; c < 4; c++) begin
        state_out[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
      end
    end
  end

endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 decryptor: expands the key forward to round key 10, then runs one
// inverse round per clock while stepping the key schedule backwards.
module aes_decrypt_top
  import aes_dec_pkg::*;
(
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  aes_state_e         state_q, state_d;
  logic [RcWidth-1:0] rc_q, rc_d;
  logic [127:0]       data_q, data_d;
  logic [KeyBits-1:0] key_q, key_d;
  logic [127:0]       out_q, out_d;
  logic               valid_q, valid_d;

  logic [31:0]        w0, w1, w2, w3;
  logic [31:0]        fwd_t, fwd0, fwd1, fwd2, rev3;
  logic [KeyBits-1:0] key_fwd, key_rev;
  logic [127:0]       round_out;

  assign {w0, w1, w2, w3} = key_q;

  // Forward step rk_{r-1} -> rk_r with Rcon[rc].
  assign fwd_t   = sub_word(rot_word(w3)) ^ {rcon(rc_q), 24'h0};
  assign fwd0    = w0 ^ fwd_t;
  assign fwd1    = w1 ^ fwd0;
  assign fwd2    = w2 ^ fwd1;
  assign key_fwd = {fwd0, fwd1, fwd2, w3 ^ fwd2};

  // Reverse step rk_r -> rk_{r-1}; the recovered w3 feeds the SubWord term.
  assign rev3    = w3 ^ w2;
  assign key_rev = {w0 ^ sub_word(rot_word(rev3)) ^ {rcon(rc_q), 24'h0}, w1 ^ w0, w2 ^ w1, rev3};

  aes_inv_round u_inv_round (
    .state_in   (data_q),
    .round_key  (key_q),
    .last_round (state_q == StFinal),
    .state_out  (round_out)
  );

  // State, counter, key and output registers.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= StIdle;
      rc_q    <= '0;
      data_q  <= '0;
      key_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      data_q  <= data_d;
      key_q   <= key_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  // Sequencing: capture, key expansion, initial AddRoundKey, nine full rounds, final round.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    data_d  = data_q;
    key_d   = key_q;
    out_d   = out_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (AES_en) begin
          data_d  = AES_data_in;
          key_d   = AES_key_in;
          rc_d    = RcOne;
          state_d = StKeyExp;
        end
      end
      StKeyExp: begin
        key_d = key_fwd;
        // rc stays at 10 so the following reverse step uses Rcon[10].
        if (rc_q == RcLast) state_d = StAddKey;
        else                rc_d    = rc_q + RcOne;
      end
      StAddKey: begin
        data_d  = data_q ^ key_q;
        key_d   = key_rev;
        rc_d    = RcRound;
        state_d = StRound;
      end
      StRound: begin
        data_d = round_out;
        key_d  = key_rev;
        rc_d   = rc_q - RcOne;
        if (rc_q == RcOne) state_d = StFinal;
      end
      StFinal: begin
        out_d   = round_out;
        valid_d = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign AES_data_out       = out_q;
  assign AES_data_out_valid = valid_q;

endmodule
